// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types and frame constants for the PS/2 receiver.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;
endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: FIFO read port, status and error pulses.
interface ps2_rx_fifo_if
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    logic                          rd_en;
    logic [PS2_DATA_BITS-1:0]      dout;
    logic                          valid;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          parity_err;
    logic                          frame_err;
    logic                          overrun;
    logic                          busy;

    modport master (
        input  rd_en,
        output dout, valid, count, parity_err, frame_err, overrun, busy
    );

    modport slave (
        output rd_en,
        input  dout, valid, count, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronises ps2c/ps2d and debounces ps2c; emits a registered falling-edge pulse.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2c,
    input  logic i_ps2d,
    output logic o_ps2d_s,
    output logic o_fall_edge
);
    logic [1:0]            r_c_sync;
    logic [1:0]            r_d_sync;
    logic [FILTER_LEN-1:0] r_filt_sr;
    logic                  r_filt;
    logic                  r_fall;
    logic                  w_filt_nxt;

    // Filtered clock only moves once the whole window agrees.
    always_comb begin
        w_filt_nxt = r_filt;
        if (&r_filt_sr)
            w_filt_nxt = 1'b1;
        else if (~|r_filt_sr)
            w_filt_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c_sync  <= '1;
            r_d_sync  <= '1;
            r_filt_sr <= '1;
            r_filt    <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_c_sync  <= {r_c_sync[0], i_ps2c};
            r_d_sync  <= {r_d_sync[0], i_ps2d};
            r_filt_sr <= {r_filt_sr[FILTER_LEN-2:0], r_c_sync[1]};
            r_filt    <= w_filt_nxt;
            r_fall    <= r_filt & ~w_filt_nxt;
        end
    end

    assign o_ps2d_s    = r_d_sync[1];
    assign o_fall_edge = r_fall;
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with frame checking and a first-word-fall-through byte FIFO.
// Define PS2_RX_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYC cycles.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2c,
    input  logic          ps2d,
    input  logic          rx_en,
    ps2_rx_fifo_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = PS2_FRAME_BITS - 1;

    logic                     w_ps2d_s;
    logic                     w_fall;
    state_t                   r_state, w_state_nxt;
    logic [3:0]               r_bit_cnt, w_bit_cnt_nxt;
    logic [SW-1:0]            r_shreg, w_shreg_nxt;
    logic                     r_pe, r_fe, r_ov;
    logic                     w_pe_nxt, w_fe_nxt, w_ov_nxt;
    logic                     w_push, w_pop, w_full;
    logic [PS2_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]            r_wptr, r_rptr;
    logic [CW-1:0]            r_count;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk         (clk),
        .reset       (reset),
        .i_ps2c      (ps2c),
        .i_ps2d      (ps2d),
        .o_ps2d_s    (w_ps2d_s),
        .o_fall_edge (w_fall)
    );

    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_pop  = bus.rd_en && (r_count != '0);

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic            w_to_hit;

    assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_to_cnt_nxt = '0;
        if (r_state == DATA && !w_fall && !w_to_hit)
            w_to_cnt_nxt = r_to_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_to_cnt <= '0;
        else       r_to_cnt <= w_to_cnt_nxt;
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_push        = 1'b0;
        w_pe_nxt      = 1'b0;
        w_fe_nxt      = 1'b0;
        w_ov_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall && rx_en && !w_ps2d_s) begin
                    w_state_nxt   = DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (w_fall) begin
                    w_shreg_nxt   = {w_ps2d_s, r_shreg[SW-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd9)
                        w_state_nxt = CHECK;
                end
`ifdef PS2_RX_TIMEOUT_EN
                else if (w_to_hit) begin
                    w_state_nxt = IDLE;
                    w_shreg_nxt = '0;
                    w_fe_nxt    = 1'b1;
                end
`endif
            end
            CHECK: begin
                // shreg holds {stop, parity, data[7:0]}; odd parity means XOR of all nine is 1.
                w_state_nxt = IDLE;
                if (!r_shreg[SW-1])
                    w_fe_nxt = 1'b1;
                else if (!(^r_shreg[SW-2:0]))
                    w_pe_nxt = 1'b1;
                else if (w_full && !bus.rd_en)
                    w_ov_nxt = 1'b1;
                else
                    w_push = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_pe      <= 1'b0;
            r_fe      <= 1'b0;
            r_ov      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_pe      <= w_pe_nxt;
            r_fe      <= w_fe_nxt;
            r_ov      <= w_ov_nxt;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= r_shreg[PS2_DATA_BITS-1:0];
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.dout       = r_mem[r_rptr];
    assign bus.valid      = (r_count != '0);
    assign bus.count      = r_count;
    assign bus.parity_err = r_pe;
    assign bus.frame_err  = r_fe;
    assign bus.overrun    = r_ov;
    assign bus.busy       = (r_state != IDLE);
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, successor to the single-frame PS/2 receiver.
- Inputs: ps2c/ps2d, synchronised and glitch-filtered at configurable depth.
- Frame checks: start bit, odd parity and stop bit are validated.
- Storage: good bytes go into a small first-word-fall-through FIFO.
- Abort: an inactivity watchdog aborts stalled frames.
- Consumers: keyboard/mouse decode logic, which drains bytes via rd_en.

Parameters:
- FILTER_LEN, 8, filtered-clock shift-register length in clk cycles (≥2).
- FIFO_DEPTH, 4, byte FIFO entries (power of 2, ≥2).
- TIMEOUT_CYC, 100000, clk cycles without a falling edge before mid-frame abort (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2c  in  1  raw PS/2 clock line.
- ps2d  in  1  raw PS/2 data line.
- rx_en  in  1  permits the start of a new frame.
- rd_en  in  1  pop the FIFO head.
- dout  out  8  FIFO head byte, valid when valid=1.
- valid  out  1  FIFO not empty.
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- parity_err  out  1  one-cycle pulse: frame dropped, bad parity.
- frame_err  out  1  one-cycle pulse: frame dropped, stop=0 or timeout.
- overrun  out  1  one-cycle pulse: good frame dropped, FIFO full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset, asynchronous: all registers clear.
  - Filter and synchronisers load 1 (idle-high lines).
  - FIFO empty, FSM IDLE.
  - Outputs: dout=0, valid=0, count=0, all pulses 0, busy=0.
- Input path: ps2c and ps2d each pass a 2-FF synchroniser.
  - Synced ps2c shifts into a FILTER_LEN register.
  - Filtered clock goes to 1 when the register is all-ones, to 0 when all-zeros, else holds.
  - fall_edge is a registered 1-cycle pulse on a filtered 1→0 transition.
  - Data is sampled from synced ps2d in the same cycle fall_edge is asserted.
- FSM states: IDLE, DATA, CHECK.
  - IDLE: on fall_edge & rx_en & ps2d_s==0 (start bit), go to DATA with bit_cnt=0.
    - fall_edge with ps2d_s==1: ignored, stay IDLE.
    - rx_en low: edges ignored.
  - DATA: on each fall_edge, shift ps2d_s into a 10-bit shift register (LSB-first data, then parity, then stop) and increment bit_cnt.
    - On the 10th sample (bit_cnt==9), go to CHECK.
    - rx_en deassertion mid-frame does not abort.
  - CHECK: one cycle, always returns to IDLE. Priority order:
    - stop==0 → frame_err pulse, no push.
    - else XOR(data, parity)==0 → parity_err pulse, no push.
    - else if FIFO full and not rd_en → overrun pulse, byte discarded.
    - else push.
- Latency: CHECK is the cycle after the stop-bit fall_edge. Pushed byte appears on dout with valid=1 the cycle after CHECK.
- FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH. dout is the head (first-word fall-through).
  - rd_en while empty: ignored.
  - Push and pop in the same cycle: both succeed, including when full; count unchanged.
  - Count saturates exactly at FIFO_DEPTH; never wraps.
- Only one error/overrun pulse per frame. Pulses are registered outputs.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Defined:
  - A cycle counter in DATA clears on every fall_edge.
  - When it reaches TIMEOUT_CYC-1: FSM → IDLE, shift register cleared, frame_err pulses one cycle, no push.
  - Counter is held at 0 outside DATA.
- Undefined:
  - No counter logic is instantiated.
  - A stalled frame waits in DATA indefinitely; only reset recovers.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, CHECK).
  - PS2_FRAME_BITS=11, PS2_DATA_BITS=8.
- Sub-module ps2_clk_filter, parameter FILTER_LEN.
  - Contains the synchronisers and the filter.
  - Outputs ps2d_s and fall_edge.
- FIFO and FSM stay in the top module.

Test Plan:
- Clean frame 0x1C (start 0, data LSB-first, parity 0, stop 1) with ~40 µs PS/2 half-periods → valid=1, dout=0x1C, count=1 the cycle after CHECK; rd_en → valid=0.
- Byte 0x1C sent with parity 1 → parity_err one pulse, count stays 0. Byte 0xF0 with stop=0 → frame_err one pulse.
- Five good frames 0x01..0x05, no reads, FIFO_DEPTH=4 → count=4, overrun on the 5th. Reads return 0x01..0x04, then valid=0.
- 3-cycle low glitch on ps2c (< FILTER_LEN) in IDLE → no fall_edge, busy stays 0. rx_en=0 with full frame → nothing captured.
- With PS2_RX_TIMEOUT_EN and TIMEOUT_CYC=1000: stop after 5 bits → frame_err after 1000 cycles, busy=0. Following frame 0x5A received correctly.
- Reset asserted mid-frame, then released → all outputs 0 immediately. Next full frame 0xAA received correctly. FIFO full with simultaneous push+pop → count stays 4, no overrun.
